// File: rtl/inta_sequencer.sv
// Interrupt acknowledge sequencer: turns the PIC INT request into a NINTA pulse train and
// hands the captured vector to the core. Define INTA_MODE_8080_EN for the 3-pulse 8080 mode.
module inta_sequencer #(
    parameter int PULSE_W     = 4,
    parameter int GAP_W       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        CLK,
    input  logic        NRESET,
    input  logic        INT,
    input  logic        IEN,
    input  logic [7:0]  D,
    output logic        NINTA,
`ifdef INTA_MODE_8080_EN
    output logic [15:0] VECTOR,
`else
    output logic [7:0]  VECTOR,
`endif
    output logic        VEC_VALID,
    input  logic        VEC_ACK,
    output logic        BUSY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_P1,
        S_G1,
        S_P2,
        S_G2,
        S_P3,
        S_DONE
    } state_t;

    localparam logic [7:0] PULSE_LOAD  = 8'(PULSE_W - 1);
    localparam logic [7:0] GAP_LOAD    = 8'(GAP_W - 1);
    localparam logic [7:0] CALL_OPCODE = 8'hCD;

    state_t                 state;
    logic [7:0]             count;
    logic [SYNC_STAGES-1:0] sync;
    logic                   int_s;

    assign int_s = sync[SYNC_STAGES-1];

    // NOTE: every output is assigned the value it must hold in the *next* state, so the
    // pins come straight from flops and NINTA cannot glitch; all updates are non-blocking.
    always_ff @(posedge CLK) begin
        if (!NRESET) begin
            // NOTE: VECTOR is a datapath register but is still cleared, so a reset
            // mid-sequence can never leave a half-captured vector visible to the core.
            state     <= S_IDLE;
            count     <= 8'd0;
            sync      <= '0;
            NINTA     <= 1'b1;
            VECTOR    <= '0;
            VEC_VALID <= 1'b0;
            BUSY      <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], INT};

            // The DONE set below never coincides with this clear: DONE implies VEC_VALID=0.
            if (VEC_VALID && VEC_ACK) begin
                VEC_VALID <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    // VEC_VALID is the registered value, so an ACK this cycle delays start by one.
                    if (int_s && IEN && !VEC_VALID) begin
                        state <= S_P1;
                        count <= PULSE_LOAD;
                        NINTA <= 1'b0;
                        BUSY  <= 1'b1;
                    end
                end

                S_P1: begin
                    if (count == 8'd0) begin
`ifdef INTA_MODE_8080_EN
                        if (D != CALL_OPCODE) begin
                            state <= S_IDLE;
                            NINTA <= 1'b1;
                            BUSY  <= 1'b0;
                        end else begin
                            state <= S_G1;
                            count <= GAP_LOAD;
                            NINTA <= 1'b1;
                        end
`else
                        state <= S_G1;
                        count <= GAP_LOAD;
                        NINTA <= 1'b1;
`endif
                    end else begin
                        count <= count - 8'd1;
                    end
                end

                S_G1: begin
                    if (count == 8'd0) begin
                        state <= S_P2;
                        count <= PULSE_LOAD;
                        NINTA <= 1'b0;
                    end else begin
                        count <= count - 8'd1;
                    end
                end

                S_P2: begin
                    if (count == 8'd0) begin
`ifdef INTA_MODE_8080_EN
                        VECTOR[7:0] <= D;
                        state       <= S_G2;
                        count       <= GAP_LOAD;
`else
                        VECTOR      <= D;
                        state       <= S_DONE;
`endif
                        NINTA <= 1'b1;
                    end else begin
                        count <= count - 8'd1;
                    end
                end

`ifdef INTA_MODE_8080_EN
                S_G2: begin
                    if (count == 8'd0) begin
                        state <= S_P3;
                        count <= PULSE_LOAD;
                        NINTA <= 1'b0;
                    end else begin
                        count <= count - 8'd1;
                    end
                end

                S_P3: begin
                    if (count == 8'd0) begin
                        VECTOR[15:8] <= D;
                        state        <= S_DONE;
                        NINTA        <= 1'b1;
                    end else begin
                        count <= count - 8'd1;
                    end
                end
`endif

                S_DONE: begin
                    VEC_VALID <= 1'b1;
                    state     <= S_IDLE;
                    BUSY      <= 1'b0;
                end

                default: begin
                    state <= S_IDLE;
                    count <= 8'd0;
                    NINTA <= 1'b1;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inta_sequencer.sv
// Bench for inta_sequencer: a position-in-sequence model predicts every output each cycle,
// and directed scenarios pin pulse widths, latencies and captured vectors to literal values.
module tb_inta_sequencer;

    localparam int PW = 4;
    localparam int GW = 4;
    localparam int SS = 2;
`ifdef INTA_MODE_8080_EN
    localparam int NP = 3;
    localparam int VW = 16;
`else
    localparam int NP = 2;
    localparam int VW = 8;
`endif
    // Model position of the DONE cycle; pulse k spans [k*(PW+GW), k*(PW+GW)+PW).
    localparam int LAST = NP * PW + (NP - 1) * GW;

    logic          clk     = 1'b0;
    logic          nreset  = 1'b0;
    logic          int_r   = 1'b0;
    logic          ien     = 1'b0;
    logic          vec_ack = 1'b0;
    logic [7:0]    d       = 8'hEE;
    logic          ninta;
    logic          vec_valid;
    logic          busy;
    logic [VW-1:0] vector;

    always #5 clk = ~clk;

    inta_sequencer #(.PULSE_W(PW), .GAP_W(GW), .SYNC_STAGES(SS)) dut (
        .CLK      (clk),
        .NRESET   (nreset),
        .INT      (int_r),
        .IEN      (ien),
        .D        (d),
        .NINTA    (ninta),
        .VECTOR   (vector),
        .VEC_VALID(vec_valid),
        .VEC_ACK  (vec_ack),
        .BUSY     (busy)
    );

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- behavioural model ----------------
    int            m_pos  = -1;
    logic          m_valid = 1'b0;
    logic [VW-1:0] m_vec   = '0;
    logic [SS-1:0] m_sync  = '0;
    logic [7:0]    tbl [3];

    function automatic int pulse_of(input int pos);
        for (int k = 0; k < NP; k++)
            if (pos >= k * (PW + GW) && pos < k * (PW + GW) + PW) return k;
        return -1;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!nreset) begin
            m_pos   <= -1;
            m_valid <= 1'b0;
            m_vec   <= '0;
            m_sync  <= '0;
        end else begin
            m_sync <= {m_sync[SS-2:0], int_r};
            if (m_valid && vec_ack) m_valid <= 1'b0;
            if (m_pos < 0) begin
                if (m_sync[SS-1] && ien && !m_valid) m_pos <= 0;
            end else if (m_pos == LAST) begin
                m_pos   <= -1;
                m_valid <= 1'b1;
            end else begin
                m_pos <= m_pos + 1;
            end
`ifdef INTA_MODE_8080_EN
            if (m_pos == PW - 1 && d != 8'hCD) m_pos <= -1;
            if (m_pos == (PW + GW) + PW - 1) m_vec[7:0] <= d;
            if (m_pos == 2 * (PW + GW) + PW - 1) m_vec[15:8] <= d;
`else
            if (m_pos == (PW + GW) + PW - 1) m_vec <= d;
`endif
        end
    end

    // PIC responder: drives the table byte for the pulse the model says is active.
    always @(negedge clk) begin
        int k;
        k = pulse_of(m_pos);
        d = (k >= 0) ? tbl[k] : 8'hEE;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("ninta",     32'(ninta),     32'(pulse_of(m_pos) < 0));
            check("busy",      32'(busy),      32'(m_pos >= 0));
            check("vec_valid", 32'(vec_valid), 32'(m_valid));
            check("vector",    32'(vector),    32'(m_vec));
        end
    end

    // ---------------- edge recorder ----------------
    int   fall_cyc [$];
    int   rise_cyc [$];
    int   vv_cyc  = 0;
    logic prev_n  = 1'b1;
    logic prev_vv = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            if (prev_n && !ninta) fall_cyc.push_back(cyc);
            if (!prev_n && ninta) rise_cyc.push_back(cyc);
            if (!prev_vv && vec_valid) vv_cyc = cyc;
            prev_n  = ninta;
            prev_vv = vec_valid;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 300 && !vec_valid; i++) step();
        check({name, "_valid_timeout"}, 32'(vec_valid), 32'd1);
    endtask

    task automatic wait_falls(input int n, input string name);
        for (int i = 0; i < 300 && fall_cyc.size() < n; i++) step();
        check({name, "_fall_timeout"}, 32'(fall_cyc.size() >= n), 32'd1);
    endtask

    task automatic ack_once();
        vec_ack = 1'b1;
        step();
        vec_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ic, a, n0, r0;
        tbl[0] = 8'h99; tbl[1] = 8'h4B; tbl[2] = 8'hEE;
        nreset = 1'b0;
        step();
        chk_en = 1'b1;
        repeat (2) step();
        check("rst_ninta",  32'(ninta),     32'd1);
        check("rst_vector", 32'(vector),    32'd0);
        check("rst_valid",  32'(vec_valid), 32'd0);
        check("rst_busy",   32'(busy),      32'd0);
        nreset = 1'b1;
        step();

`ifndef INTA_MODE_8080_EN
        // Basic acknowledge
        n0 = fall_cyc.size(); r0 = rise_cyc.size();
        ien = 1'b1; int_r = 1'b1; ic = cyc;
        wait_valid("basic");
        check("basic_first_low", 32'(fall_cyc[n0] - ic), 32'(SS + 1));
        check("basic_p1_width",  32'(rise_cyc[r0] - fall_cyc[n0]), 32'd4);
        check("basic_gap_width", 32'(fall_cyc[n0+1] - rise_cyc[r0]), 32'd4);
        check("basic_p2_width",  32'(rise_cyc[r0+1] - fall_cyc[n0+1]), 32'd4);
        check("basic_latency",   32'(vv_cyc - ic - SS), 32'd14);
        check("basic_vector",    32'(vector), 32'h4B);

        // Back-pressure with INT still asserted
        repeat (30) step();
        check("bp_no_third_pulse", 32'(fall_cyc.size() - n0), 32'd2);
        check("bp_vector",         32'(vector), 32'h4B);
        check("bp_valid",          32'(vec_valid), 32'd1);
        tbl[1] = 8'h5A;
        a = cyc;
        ack_once();
        check("bp_valid_cleared", 32'(vec_valid), 32'd0);
        wait_falls(n0 + 3, "bp_restart");
        check("bp_restart_delay", 32'(fall_cyc[n0+2] - a), 32'd2);
        int_r = 1'b0;
        wait_valid("bp_second");
        check("bp_second_vector", 32'(vector), 32'h5A);
        ack_once();
        repeat (5) step();

        // IEN gating
        ien = 1'b0; int_r = 1'b1;
        n0 = fall_cyc.size(); r0 = rise_cyc.size();
        repeat (50) step();
        check("gate_ninta", 32'(ninta), 32'd1);
        check("gate_busy",  32'(busy),  32'd0);
        check("gate_no_pulse", 32'(fall_cyc.size() - n0), 32'd0);
        tbl[1] = 8'h21;
        ien = 1'b1; a = cyc;
        wait_falls(n0 + 1, "gate_start");
        check("gate_start_delay", 32'(fall_cyc[n0] - a), 32'd1);

        // INT and IEN drop during G1: sequence still completes
        for (int i = 0; i < 50 && rise_cyc.size() <= r0; i++) step();
        int_r = 1'b0; ien = 1'b0;
        wait_valid("drop");
        check("drop_vector", 32'(vector), 32'h21);
        check("drop_pulses", 32'(fall_cyc.size() - n0), 32'd2);
        ack_once();
        repeat (5) step();

        // Reset during the second cycle of P2
        tbl[1] = 8'h77;
        n0 = fall_cyc.size();
        ien = 1'b1; int_r = 1'b1;
        wait_falls(n0 + 2, "rst_mid");
        step();
        nreset = 1'b0;
        step();
        check("rstmid_ninta",  32'(ninta),     32'd1);
        check("rstmid_valid",  32'(vec_valid), 32'd0);
        check("rstmid_vector", 32'(vector),    32'd0);
        check("rstmid_busy",   32'(busy),      32'd0);
        nreset = 1'b1; int_r = 1'b0; ien = 1'b0;
        repeat (10) step();
        check("rstmid_no_capture", 32'(vector), 32'd0);
`else
        // Three-pulse 8080 sequence
        tbl[0] = 8'hCD; tbl[1] = 8'h34; tbl[2] = 8'h12;
        n0 = fall_cyc.size();
        ien = 1'b1; int_r = 1'b1; ic = cyc;
        wait_valid("i80");
        int_r = 1'b0;
        check("i80_vector",  32'(vector), 32'h1234);
        check("i80_pulses",  32'(fall_cyc.size() - n0), 32'd3);
        check("i80_latency", 32'(vv_cyc - ic - SS), 32'd22);
        ack_once();
        repeat (5) step();

        // Bad opcode in P1 aborts
        tbl[0] = 8'h00;
        n0 = fall_cyc.size();
        int_r = 1'b1;
        wait_falls(n0 + 1, "abort");
        int_r = 1'b0;
        repeat (40) step();
        check("abort_valid",  32'(vec_valid), 32'd0);
        check("abort_pulses", 32'(fall_cyc.size() - n0), 32'd1);
        check("abort_busy",   32'(busy), 32'd0);
        check("abort_vector", 32'(vector), 32'h1234);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
